// File: rtl/soc_map_pkg.sv
// rtl/soc_map_pkg.sv - SoC address map, timer register offsets and CTRL bit positions
//
// Shared by the address decoder and the memory-mapped peripherals.

package soc_map_pkg;

    // Peripheral base addresses on the picoRV32 native bus
    localparam logic [31:0] UART_DIV_ADDR   = 32'h0200_0004;
    localparam logic [31:0] UART_DAT_ADDR   = 32'h0200_0008;
    localparam logic [31:0] TIMER_BASE_ADDR = 32'h0300_0000;

    // Timer register byte offsets inside its 32-byte window
    localparam logic [4:0] TMR_CTRL_OFF     = 5'h00;
    localparam logic [4:0] TMR_PRESCALE_OFF = 5'h04;
    localparam logic [4:0] TMR_COUNT_OFF    = 5'h08;
    localparam logic [4:0] TMR_COMPARE_OFF  = 5'h0C;
    localparam logic [4:0] TMR_STATUS_OFF   = 5'h10;

    // Word index of each register (mem_addr[4:2]); indices 5..7 are reserved
    typedef enum logic [2:0] {
        TMR_CTRL     = TMR_CTRL_OFF[4:2],
        TMR_PRESCALE = TMR_PRESCALE_OFF[4:2],
        TMR_COUNT    = TMR_COUNT_OFF[4:2],
        TMR_COMPARE  = TMR_COMPARE_OFF[4:2],
        TMR_STATUS   = TMR_STATUS_OFF[4:2]
    } tmr_reg_e;

    // CTRL bit positions
    localparam int CTRL_EN         = 0;
    localparam int CTRL_AUTORELOAD = 1;
    localparam int CTRL_IRQEN      = 2;
    localparam int CTRL_W          = 3;

    // Expand the four byte strobes into a 32-bit bit mask
    function automatic logic [31:0] strobe_mask(input logic [3:0] wstrb);
        return {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - divide-by-(PRESCALE+1) tick generator
//
// Ports:
//   clk, resetn  : clock, asynchronous active-low reset
//   en_i         : counting enable; pcnt is held at 0 while low
//   prescale_i   : terminal count, tick every prescale_i+1 enabled cycles
//   load_i       : prescale register is being written, restart pcnt at 0
//   tick_o       : one-cycle pulse in the cycle where pcnt == prescale_i

module timer_prescaler #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  en_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    input  logic                  load_i,
    output logic                  tick_o
);

    logic [PRESCALE_W-1:0] pcnt_q;
    logic [PRESCALE_W-1:0] pcnt_d;

    assign tick_o = en_i && (pcnt_q == prescale_i);

    always_comb begin
        if (!en_i || tick_o || load_i) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/soc_timer_responder.sv
// rtl/soc_timer_responder.sv - picoRV32-bus timer/compare peripheral with level interrupt
//
// Ports:
//   clk, resetn          : clock, asynchronous active-low reset
//   mem_valid/addr/wdata/wstrb : picoRV32 native bus request (wstrb==0 is a read)
//   mem_ready            : one-cycle acknowledge, one cycle after select
//   mem_rdata            : read data, zero whenever mem_ready is low
//   irq_out              : registered PEND && IRQEN
//   eoi_in               : end-of-interrupt, clears PEND

module soc_timer_responder
    import soc_map_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = TIMER_BASE_ADDR,
    parameter int          PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        irq_out,
    input  logic        eoi_in
);

    logic [CTRL_W-1:0]     ctrl_q,     ctrl_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [31:0]           count_q,    count_d;
    logic [31:0]           compare_q,  compare_d;
    logic                  pend_q,     pend_d;
    logic                  ready_q,    ready_d;
    logic [31:0]           rdata_q,    rdata_d;
    logic                  irq_q,      irq_d;

    logic        sel;
    logic        acc;
    logic        wr;
    logic [2:0]  idx;
    logic [31:0] wmask;
    logic [31:0] rd_mux;
    logic        tick;
    logic        match;
    logic        prescale_load;
    logic        status_clr;
    logic        unused_addr_bits;

    assign unused_addr_bits = &{1'b0, mem_addr[1:0]};

    // The !ready_q term leaves a one-cycle gap so the held valid of the
    // acknowledged transaction is not accepted twice.
    assign sel   = mem_valid && (mem_addr[31:5] == BASE_ADDR[31:5]);
    assign acc   = sel && !ready_q;
    assign wr    = acc && (mem_wstrb != 4'b0000);
    assign idx   = mem_addr[4:2];
    assign wmask = strobe_mask(mem_wstrb);
    assign match = tick && (count_q == compare_q);

    timer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk        (clk),
        .resetn     (resetn),
        .en_i       (ctrl_q[CTRL_EN]),
        .prescale_i (prescale_q),
        .load_i     (prescale_load),
        .tick_o     (tick)
    );

    always_comb begin
        rd_mux = '0;
        case (idx)
            TMR_CTRL:     rd_mux = 32'(ctrl_q);
            TMR_PRESCALE: rd_mux = 32'(prescale_q);
            TMR_COUNT:    rd_mux = count_q;
            TMR_COMPARE:  rd_mux = compare_q;
            TMR_STATUS:   rd_mux = 32'(pend_q);
            default:      rd_mux = '0;
        endcase
    end

    always_comb begin
        ctrl_d        = ctrl_q;
        prescale_d    = prescale_q;
        count_d       = count_q;
        compare_d     = compare_q;
        prescale_load = 1'b0;
        status_clr    = 1'b0;

        if (tick) begin
            count_d = (match && ctrl_q[CTRL_AUTORELOAD]) ? 32'd0 : count_q + 32'd1;
        end

        // A bus write overrides the tick update of the same register
        if (wr) begin
            case (idx)
                TMR_CTRL: begin
                    ctrl_d = (ctrl_q & ~wmask[CTRL_W-1:0]) | (mem_wdata[CTRL_W-1:0] & wmask[CTRL_W-1:0]);
                end
                TMR_PRESCALE: begin
                    prescale_d    = (prescale_q & ~wmask[PRESCALE_W-1:0])
                                  | (mem_wdata[PRESCALE_W-1:0] & wmask[PRESCALE_W-1:0]);
                    prescale_load = 1'b1;
                end
                TMR_COUNT:   count_d    = (count_q & ~wmask) | (mem_wdata & wmask);
                TMR_COMPARE: compare_d  = (compare_q & ~wmask) | (mem_wdata & wmask);
                TMR_STATUS:  status_clr = wmask[0] && mem_wdata[0];
                default: ;
            endcase
        end

        // A match in the same cycle as a clear keeps PEND set
        pend_d = pend_q;
        if (match) begin
            pend_d = 1'b1;
        end else if (eoi_in || status_clr) begin
            pend_d = 1'b0;
        end

        // Built from next-state values so irq_out follows PEND with no extra lag
        irq_d   = pend_d && ctrl_d[CTRL_IRQEN];
        ready_d = acc;
        rdata_d = (acc && !wr) ? rd_mux : 32'd0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            pend_q     <= 1'b0;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            pend_q     <= pend_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
        end
    end

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;
    assign irq_out   = irq_q;

endmodule

// File: tb/tb_soc_timer_responder.sv
// tb/tb_soc_timer_responder.sv - self-checking bench for soc_timer_responder

module tb_soc_timer_responder;
    import soc_map_pkg::*;

    localparam logic [31:0] BASE = 32'h0300_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        irq_out;
    logic        eoi_in = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference state, in register terms
    logic [31:0] m_ctrl, m_pre, m_pcnt, m_count, m_cmp, m_rdata;
    logic        m_pend, m_ready, m_irq;

    always #5 clk = ~clk;

    soc_timer_responder #(
        .BASE_ADDR  (BASE),
        .PRESCALE_W (16)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .irq_out   (irq_out),
        .eoi_in    (eoi_in)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_ctrl = 0; m_pre = 0; m_pcnt = 0; m_count = 0; m_cmp = 0;
        m_rdata = 0; m_pend = 0; m_ready = 0; m_irq = 0;
    endfunction

    // Advance the reference by one clock edge given the inputs seen at that edge
    function automatic void model_edge(input logic v, input logic [31:0] a, input logic [31:0] d,
                                       input logic [3:0] s, input logic e);
        logic sel, acc, wr, tick, match, n_pend;
        logic [2:0]  idx;
        logic [31:0] rd, val, n_ctrl, n_pre, n_pcnt, n_count, n_cmp;
        sel   = v && (a[31:5] == BASE[31:5]);
        acc   = sel && !m_ready;
        wr    = acc && (s != 4'b0000);
        idx   = a[4:2];
        tick  = m_ctrl[0] && (m_pcnt == m_pre);
        match = tick && (m_count == m_cmp);
        rd    = 0;
        if (acc && !wr) begin
            case (idx)
                3'd0: rd = m_ctrl;
                3'd1: rd = m_pre;
                3'd2: rd = m_count;
                3'd3: rd = m_cmp;
                3'd4: rd = {31'b0, m_pend};
                default: rd = 0;
            endcase
        end
        n_ctrl = m_ctrl; n_pre = m_pre; n_count = m_count; n_cmp = m_cmp; n_pend = m_pend;
        n_pcnt = (m_ctrl[0] && !tick) ? m_pcnt + 1 : 0;
        if (tick) n_count = (match && m_ctrl[1]) ? 0 : m_count + 1;
        if (e) n_pend = 0;
        if (wr) begin
            case (idx)
                3'd0: val = m_ctrl;
                3'd1: val = m_pre;
                3'd2: val = m_count;
                3'd3: val = m_cmp;
                default: val = 0;
            endcase
            for (int b = 0; b < 4; b++) if (s[b]) val[8*b +: 8] = d[8*b +: 8];
            case (idx)
                3'd0: n_ctrl = val & 32'h7;
                3'd1: begin n_pre = val & 32'hFFFF; n_pcnt = 0; end
                3'd2: n_count = val;
                3'd3: n_cmp = val;
                3'd4: if (s[0] && d[0]) n_pend = 0;
                default: ;
            endcase
        end
        if (match) n_pend = 1;
        m_ctrl = n_ctrl; m_pre = n_pre; m_pcnt = n_pcnt; m_count = n_count; m_cmp = n_cmp;
        m_pend = n_pend; m_irq = n_pend && n_ctrl[2]; m_ready = acc; m_rdata = rd;
    endfunction

    // Drive one clock of inputs, step the reference, compare all outputs
    task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic e);
        @(negedge clk);
        mem_valid = v; mem_addr = a; mem_wdata = d; mem_wstrb = s; eoi_in = e;
        model_edge(v, a, d, s, e);
        @(posedge clk);
        #1;
        chk("cyc_ready", 32'(mem_ready), 32'(m_ready));
        chk("cyc_rdata", mem_rdata, m_rdata);
        chk("cyc_irq", 32'(irq_out), 32'(m_irq));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    endtask

    // Core holds valid through the acknowledge cycle; returns first-cycle ready/rdata
    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic r, output logic [31:0] rd);
        cycle(1'b1, a, d, s, 1'b0);
        r  = mem_ready;
        rd = mem_rdata;
        cycle(1'b1, a, d, s, 1'b0);
        chk("ready_single_pulse", 32'(mem_ready), 32'd0);
    endtask

    function automatic logic match_now();
        return m_ctrl[0] && (m_pcnt == m_pre) && (m_count == m_cmp);
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        exp_ready;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic        r;
        logic [31:0] rd;
        int          n;
        int          rises[$];
        logic        prev;
        logic [2:0]  ridx;
        logic [31:0] ra, rw;

        m_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 32'(mem_ready), 32'd0);
        chk("reset_rdata", mem_rdata, 32'd0);
        chk("reset_irq", 32'(irq_out), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Register access table
        for (int o = 0; o < 8; o++) vecs.push_back('{BASE + 32'(o * 4), 32'd0, 4'b0000, 1'b1, 32'd0});
        vecs.push_back('{32'h0400_0000, 32'd0, 4'b0000, 1'b0, 32'd0});
        vecs.push_back('{UART_DIV_ADDR, 32'd0, 4'b0000, 1'b0, 32'd0});
        vecs.push_back('{UART_DAT_ADDR, 32'hFFFF_FFFF, 4'b1111, 1'b0, 32'd0});
        vecs.push_back('{BASE + 32'h0C, 32'hAABB_CCDD, 4'b0010, 1'b1, 32'd0});
        vecs.push_back('{BASE + 32'h0C, 32'd0, 4'b0000, 1'b1, 32'h0000_CC00});
        vecs.push_back('{BASE + 32'h0F, 32'd0, 4'b0000, 1'b1, 32'h0000_CC00});
        vecs.push_back('{BASE + 32'h14, 32'hFFFF_FFFF, 4'b1111, 1'b1, 32'd0});
        vecs.push_back('{BASE + 32'h14, 32'd0, 4'b0000, 1'b1, 32'd0});
        vecs.push_back('{BASE + 32'h00, 32'hFFFF_FFF8, 4'b1111, 1'b1, 32'd0});
        vecs.push_back('{BASE + 32'h00, 32'd0, 4'b0000, 1'b1, 32'd0});
        vecs.push_back('{BASE + 32'h00, 32'h0000_0006, 4'b0001, 1'b1, 32'd0});
        vecs.push_back('{BASE + 32'h00, 32'h0000_0007, 4'b0000, 1'b1, 32'd6});
        vecs.push_back('{BASE + 32'h04, 32'h0001_2345, 4'b1111, 1'b1, 32'd0});
        vecs.push_back('{BASE + 32'h04, 32'd0, 4'b0000, 1'b1, 32'h0000_2345});
        vecs.push_back('{BASE + 32'h00, 32'd0, 4'b1111, 1'b1, 32'd0});
        vecs.push_back('{BASE + 32'h04, 32'd0, 4'b1111, 1'b1, 32'd0});
        vecs.push_back('{BASE + 32'h08, 32'd0, 4'b1111, 1'b1, 32'd0});
        vecs.push_back('{BASE + 32'h0C, 32'd5, 4'b1111, 1'b1, 32'd0});
        vecs.push_back('{BASE + 32'h0C, 32'd0, 4'b0000, 1'b1, 32'd5});
        foreach (vecs[i]) begin
            bus(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, r, rd);
            chk($sformatf("vec%0d_ready", i), 32'(r), 32'(vecs[i].exp_ready));
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
        end

        // PRESCALE=0, COMPARE=5, EN|IRQEN: sixth tick sets PEND
        bus(BASE + 32'h00, 32'h5, 4'b0001, r, rd);
        n = 1;
        while (!irq_out && n < 20) begin
            idle(1);
            n++;
        end
        chk("irq_after_6_ticks", 32'(n), 32'd6);
        bus(BASE + 32'h08, 32'd0, 4'b0000, r, rd);
        chk("count_after_match", rd, 32'd6);
        bus(BASE + 32'h08, 32'd0, 4'b0000, r, rd);
        chk("count_continues", rd, 32'd8);
        bus(BASE + 32'h00, 32'd0, 4'b1111, r, rd);
        bus(BASE + 32'h10, 32'd1, 4'b0001, r, rd);
        bus(BASE + 32'h10, 32'd0, 4'b0000, r, rd);
        chk("status_w1c", rd, 32'd0);

        // PRESCALE=3, AUTORELOAD, COMPARE=2: PEND every 12 clocks
        bus(BASE + 32'h04, 32'd3, 4'b1111, r, rd);
        bus(BASE + 32'h0C, 32'd2, 4'b1111, r, rd);
        bus(BASE + 32'h08, 32'd0, 4'b1111, r, rd);
        bus(BASE + 32'h00, 32'h7, 4'b0001, r, rd);
        prev = irq_out;
        for (int k = 1; k <= 80; k++) begin
            cycle(1'b0, 32'd0, 32'd0, 4'd0, irq_out);
            if (irq_out && !prev) rises.push_back(k);
            prev = irq_out;
        end
        chk("autoreload_rises", 32'(rises.size() >= 3), 32'd1);
        if (rises.size() >= 3) begin
            chk("autoreload_period0", 32'(rises[1] - rises[0]), 32'd12);
            chk("autoreload_period1", 32'(rises[2] - rises[1]), 32'd12);
        end

        // Match coincident with eoi_in: set wins
        n = 0;
        while (!match_now() && n < 40) begin
            cycle(1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
            n++;
        end
        chk("eoi_search_bound", 32'(n < 40), 32'd1);
        cycle(1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
        chk("eoi_coincident_irq", 32'(irq_out), 32'd1);
        cycle(1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
        chk("eoi_alone_clears", 32'(irq_out), 32'd0);

        // Match coincident with STATUS write-1: set wins
        n = 0;
        while (!match_now() && n < 40) begin
            cycle(1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
            n++;
        end
        chk("w1c_search_bound", 32'(n < 40), 32'd1);
        bus(BASE + 32'h10, 32'd1, 4'b0001, r, rd);
        chk("w1c_coincident_irq", 32'(irq_out), 32'd1);
        bus(BASE + 32'h10, 32'd0, 4'b0000, r, rd);
        chk("w1c_coincident_pend", rd, 32'd1);
        cycle(1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
        chk("eoi_after_w1c_clears", 32'(irq_out), 32'd0);

        // Wrap: COUNT=FFFF_FFFF, COMPARE=0, PRESCALE=20 (tick every 21 clocks)
        bus(BASE + 32'h00, 32'd0, 4'b1111, r, rd);
        bus(BASE + 32'h04, 32'd20, 4'b1111, r, rd);
        bus(BASE + 32'h0C, 32'd0, 4'b1111, r, rd);
        bus(BASE + 32'h08, 32'hFFFF_FFFF, 4'b1111, r, rd);
        bus(BASE + 32'h10, 32'd1, 4'b0001, r, rd);
        bus(BASE + 32'h00, 32'd1, 4'b0001, r, rd);
        idle(22);
        bus(BASE + 32'h08, 32'd0, 4'b0000, r, rd);
        chk("wrap_count_zero", rd, 32'd0);
        bus(BASE + 32'h10, 32'd0, 4'b0000, r, rd);
        chk("wrap_no_pend", rd, 32'd0);
        idle(17);
        bus(BASE + 32'h08, 32'd0, 4'b0000, r, rd);
        chk("wrap_then_match_count", rd, 32'd1);
        bus(BASE + 32'h10, 32'd0, 4'b0000, r, rd);
        chk("wrap_then_match_pend", rd, 32'd1);

        // Randomized traffic against the reference
        for (int t = 0; t < 250; t++) begin
            n = $urandom_range(0, 2);
            for (int i = 0; i < n; i++)
                cycle(1'b0, 32'd0, 32'd0, 4'd0, ($urandom_range(0, 15) == 0));
            ridx = 3'($urandom_range(0, 7));
            ra = (($urandom_range(0, 9) == 0) ? 32'h0400_0000 : BASE)
               | {27'd0, ridx, 2'($urandom_range(0, 3))};
            case (ridx)
                3'd1:    rw = $urandom_range(0, 3);
                3'd2:    rw = $urandom_range(0, 15);
                3'd3:    rw = $urandom_range(0, 15);
                default: rw = $urandom;
            endcase
            bus(ra, rw, 4'($urandom_range(0, 15)), r, rd);
        end

        // Asynchronous reset with an acknowledge and the interrupt active
        bus(BASE + 32'h00, 32'd0, 4'b1111, r, rd);
        bus(BASE + 32'h04, 32'd0, 4'b1111, r, rd);
        bus(BASE + 32'h08, 32'd0, 4'b1111, r, rd);
        bus(BASE + 32'h0C, 32'd0, 4'b1111, r, rd);
        bus(BASE + 32'h00, 32'd5, 4'b0001, r, rd);
        chk("pre_reset_irq", 32'(irq_out), 32'd1);
        cycle(1'b1, BASE + 32'h08, 32'd0, 4'b0000, 1'b0);
        chk("pre_reset_ready", 32'(mem_ready), 32'd1);
        #2;
        resetn = 1'b0;
        mem_valid = 1'b0;
        #1;
        chk("async_reset_ready", 32'(mem_ready), 32'd0);
        chk("async_reset_rdata", mem_rdata, 32'd0);
        chk("async_reset_irq", 32'(irq_out), 32'd0);
        m_reset();
        @(negedge clk);
        resetn = 1'b1;
        bus(BASE + 32'h00, 32'd0, 4'b0000, r, rd);
        chk("post_reset_ctrl", rd, 32'd0);
        bus(BASE + 32'h08, 32'd0, 4'b0000, r, rd);
        chk("post_reset_count", rd, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
